// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared xbus arbiter state encodings and default constants
//
// Purpose: common types for xbus schedulers.
// Contents:
//   XBUS_NUM_MASTERS / XBUS_ID_W / XBUS_TIMEOUT / XBUS_CNT_W  default sizing
//   xbus_state_e                                         tenure FSM encoding
package xbus_pkg;

  localparam int XBUS_NUM_MASTERS = 4;
  localparam int XBUS_ID_W        = 2;
  localparam int XBUS_TIMEOUT     = 256;
  localparam int XBUS_CNT_W       = 9;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ARBIT = 4'd1,
    TXFER = 4'd2,
    ABORT = 4'd3,
    DRAIN = 4'd4
  } xbus_state_e;

endpackage

// File: rtl/xbus_rr_arbiter_if.sv
// rtl/xbus_rr_arbiter_if.sv - xbus arbiter request/grant/status bundle
//
// Purpose: groups the arbiter's handshake, mux-control and status signals.
// Signals:
//   ma_req, ma_select, ma_mask  per-master request, transfer select, isolation
//   sl_ack                      slave acknowledge
//   status_clr                  write-1-to-clear for timeout_status
//   gnt                         one-hot grant pulse
//   cur_id, cur_valid           bus owner and mux enable
//   err_ack, timeout_err        watchdog abort pulses
//   timeout_status              sticky per-master timeout flags
// Modports:
//   slave   arbiter side
//   master  requester/slave-port side (drives requests, observes grants)
interface xbus_rr_arbiter_if
  import xbus_pkg::*;
#(
  parameter int NUM_MASTERS = XBUS_NUM_MASTERS,
  parameter int ID_W        = XBUS_ID_W
);

  logic [NUM_MASTERS-1:0] ma_req;
  logic [NUM_MASTERS-1:0] ma_select;
  logic [NUM_MASTERS-1:0] ma_mask;
  logic                   sl_ack;
  logic [NUM_MASTERS-1:0] status_clr;
  logic [NUM_MASTERS-1:0] gnt;
  logic [ID_W-1:0]        cur_id;
  logic                   cur_valid;
  logic                   err_ack;
  logic                   timeout_err;
  logic [NUM_MASTERS-1:0] timeout_status;

  modport slave (
    input  ma_req, ma_select, ma_mask, sl_ack, status_clr,
    output gnt, cur_id, cur_valid, err_ack, timeout_err, timeout_status
  );

  modport master (
    output ma_req, ma_select, ma_mask, sl_ack, status_clr,
    input  gnt, cur_id, cur_valid, err_ack, timeout_err, timeout_status
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select
//
// Purpose: picks the first eligible requester scanning from last+1, wrapping.
// Ports:
//   eligible  in   N     request vector already qualified by masks
//   last      in   ID_W  previously served id (lowest priority this round)
//   winner    out  ID_W  selected id (0 when any is low)
//   any       out  1     at least one eligible requester
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  int idx;

  // Walk the scan order backwards so the final overwrite is the candidate
  // closest to last+1, which is the one with highest priority.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (eligible[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbus_rr_arbiter.sv
// rtl/xbus_rr_arbiter.sv - round-robin arbiter and tenure controller for xbus
//
// Purpose: grants the shared slave port to one master at a time, tracks the
// tenure, aborts tenures the slave never acks and honours isolation masks.
// Ports:
//   clk   in  clock
//   rstn  in  asynchronous active-low reset
//   bus   slave modport of xbus_rr_arbiter_if (requests, grants, status)
module xbus_rr_arbiter
  import xbus_pkg::*;
#(
  parameter int NUM_MASTERS = XBUS_NUM_MASTERS,
  parameter int ID_W        = XBUS_ID_W,
  parameter int TIMEOUT     = XBUS_TIMEOUT,
  parameter int CNT_W       = XBUS_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  xbus_rr_arbiter_if.slave  bus
);

  xbus_state_e            state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]        cur_id_q, cur_id_d;
  logic                   cur_valid_q, cur_valid_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]       wdog_q, wdog_d;
  logic [NUM_MASTERS-1:0] status_q, status_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic [ID_W-1:0]        win_id;
  logic                   win_any;

  assign eligible = bus.ma_req & ~bus.ma_mask;

  rr_pick #(
    .N    (NUM_MASTERS),
    .ID_W (ID_W)
  ) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .winner   (win_id),
    .any      (win_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      cur_id_q    <= '0;
      cur_valid_q <= 1'b0;
      last_q      <= ID_W'(NUM_MASTERS - 1);
      wdog_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cur_id_q    <= cur_id_d;
      cur_valid_q <= cur_valid_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      status_q    <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    cur_id_d    = cur_id_q;
    cur_valid_d = cur_valid_q;
    last_d      = last_q;
    wdog_d      = wdog_q;
    // Clear is applied first so a same-cycle set in ABORT overrides it.
    status_d    = status_q & ~bus.status_clr;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d  = ARBIT;
          gnt_d    = NUM_MASTERS'(1) << win_id;
          cur_id_d = win_id;
          last_d   = win_id;
        end
      end

      ARBIT: begin
        state_d     = TXFER;
        cur_valid_d = 1'b1;
        wdog_d      = '0;
      end

      TXFER: begin
        if (bus.ma_mask[cur_id_q]) begin
          // Isolation kill: silent, no error reported.
          state_d     = IDLE;
          cur_valid_d = 1'b0;
        end else if (!bus.ma_select[cur_id_q]) begin
          cur_valid_d = 1'b0;
          if (win_any) begin
            // Re-arbitrate straight away, skipping the IDLE bubble.
            state_d  = ARBIT;
            gnt_d    = NUM_MASTERS'(1) << win_id;
            cur_id_d = win_id;
            last_d   = win_id;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.sl_ack) begin
          wdog_d = '0;
        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end

      ABORT: begin
        status_d[cur_id_q] = 1'b1;
        cur_valid_d        = 1'b0;
        state_d            = DRAIN;
      end

      DRAIN: begin
        // Hold off new grants until the aborted master lets go.
        if (!bus.ma_select[cur_id_q] || bus.ma_mask[cur_id_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cur_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt            = gnt_q;
  assign bus.cur_id         = cur_id_q;
  assign bus.cur_valid      = cur_valid_q;
  assign bus.err_ack        = (state_q == ABORT);
  assign bus.timeout_err    = (state_q == ABORT);
  assign bus.timeout_status = status_q;

endmodule

// File: tb/tb_xbus_rr_arbiter.sv
// tb/tb_xbus_rr_arbiter.sv - self-checking bench for xbus_rr_arbiter
module tb_xbus_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  xbus_rr_arbiter_if #(.NUM_MASTERS(N), .ID_W(2)) bus ();

  xbus_rr_arbiter #(
    .NUM_MASTERS (N),
    .ID_W        (2),
    .TIMEOUT     (TO),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

  // Reference model: who holds the bus and which phase of the tenure we are in.
  int       m_last;
  int       m_owner;
  bit       m_granting;
  bit       m_busy;
  bit       m_aborting;
  bit       m_draining;
  bit       m_valid;
  int       m_wd;
  logic [3:0] m_status;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [3:0] elig, input int last);
    for (int k = 1; k <= N; k++) begin
      if (elig[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_last     = N - 1;
    m_owner    = 0;
    m_granting = 0;
    m_busy     = 0;
    m_aborting = 0;
    m_draining = 0;
    m_valid    = 0;
    m_wd       = 0;
    m_status   = '0;
  endfunction

  function automatic void take(input int w);
    m_owner    = w;
    m_last     = w;
    m_granting = 1;
  endfunction

  function automatic void model_step();
    logic [3:0] elig;
    int         w;
    bit         set_st;
    elig   = bus.ma_req & ~bus.ma_mask;
    w      = rr_winner(elig, m_last);
    set_st = 0;
    if (m_granting) begin
      m_granting = 0;
      m_busy     = 1;
      m_valid    = 1;
      m_wd       = 0;
    end else if (m_busy) begin
      if (bus.ma_mask[m_owner]) begin
        m_busy  = 0;
        m_valid = 0;
      end else if (!bus.ma_select[m_owner]) begin
        m_busy  = 0;
        m_valid = 0;
        if (w >= 0) take(w);
      end else if (bus.sl_ack) begin
        m_wd = 0;
      end else if (m_wd == TO - 1) begin
        m_busy     = 0;
        m_aborting = 1;
      end else begin
        m_wd++;
      end
    end else if (m_aborting) begin
      m_aborting = 0;
      set_st     = 1;
      m_valid    = 0;
      m_draining = 1;
    end else if (m_draining) begin
      if (!bus.ma_select[m_owner] || bus.ma_mask[m_owner]) m_draining = 0;
    end else if (w >= 0) begin
      take(w);
    end
    m_status = (m_status & ~bus.status_clr) | (set_st ? 4'(1 << m_owner) : 4'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", bus.gnt, m_granting ? 32'(1 << m_owner) : 32'd0);
    chk("cur_id", bus.cur_id, m_owner);
    chk("cur_valid", bus.cur_valid, m_valid);
    chk("err_ack", bus.err_ack, m_aborting);
    chk("timeout_err", bus.timeout_err, m_aborting);
    chk("timeout_status", bus.timeout_status, m_status);
  endtask

  task automatic clear_inputs();
    bus.ma_req     = '0;
    bus.ma_select  = '0;
    bus.ma_mask    = '0;
    bus.sl_ack     = 1'b0;
    bus.status_clr = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (bus.gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus.gnt == '0) chk("wait_gnt", 0, 1);
  endtask

  task automatic wait_abort();
    int n = 0;
    while (!bus.err_ack && n < 30) begin
      tick();
      n++;
    end
    if (!bus.err_ack) chk("wait_abort", 0, 1);
  endtask

  // Three select cycles with ack on the third, then release.
  task automatic tenure3(input logic [3:0] who);
    bus.ma_select = who;
    bus.sl_ack    = 1'b0;
    tick();
    tick();
    tick();
    bus.sl_ack = 1'b1;
    tick();
    bus.sl_ack    = 1'b0;
    bus.ma_select = '0;
    tick();
  endtask

  task automatic rand_cycles(input int n, input int p_ack, input int p_mask, input int p_drop);
    bit active;
    for (int i = 0; i < n; i++) begin
      active        = m_granting || m_busy || m_aborting || m_draining;
      bus.ma_req    = 4'($urandom);
      bus.ma_mask   = ($urandom_range(99) < p_mask) ? 4'($urandom) : 4'd0;
      bus.ma_select = 4'($urandom);
      if (active) bus.ma_select[m_owner] = ($urandom_range(99) >= p_drop);
      bus.sl_ack     = ($urandom_range(99) < p_ack);
      bus.status_clr = ($urandom_range(99) < 10) ? 4'($urandom) : 4'd0;
      tick();
    end
  endtask

  initial begin
    int n;
    int err_seen;
    checks = 0;
    errors = 0;

    // Reset values and round-robin order with everyone requesting.
    apply_reset();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_valid", bus.cur_valid, 0);
    chk("rst_status", bus.timeout_status, 0);
    bus.ma_req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      wait_gnt();
      chk("rr_order", bus.gnt, 32'(1 << t));
      tenure3(4'(1 << t));
    end

    // Back-to-back arbitration without an IDLE bubble.
    apply_reset();
    bus.ma_req = 4'b0110;
    wait_gnt();
    chk("b2b_first", bus.gnt, 4'b0010);
    bus.ma_select = 4'b0010;
    tick();
    tick();
    chk("b2b_valid_hi", bus.cur_valid, 1);
    bus.ma_select = '0;
    tick();
    chk("b2b_second", bus.gnt, 4'b0100);
    chk("b2b_valid_lo", bus.cur_valid, 0);
    bus.ma_select = 4'b0100;
    tick();
    chk("b2b_valid_back", bus.cur_valid, 1);

    // Watchdog abort, drain, and status clear.
    apply_reset();
    bus.ma_req = 4'b1000;
    wait_gnt();
    chk("wd_gnt", bus.gnt, 4'b1000);
    bus.ma_select = 4'b1000;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.err_ack && n < 30);
    chk("wd_latency", n, TO + 1);
    chk("wd_terr", bus.timeout_err, 1);
    tick();
    chk("wd_status", bus.timeout_status, 4'b1000);
    chk("wd_err_once", bus.err_ack, 0);
    tick();
    tick();
    chk("drain_no_gnt", bus.gnt, 0);
    bus.ma_req    = '0;
    bus.ma_select = '0;
    tick();
    bus.status_clr = 4'b1000;
    tick();
    bus.status_clr = '0;
    chk("wd_clr", bus.timeout_status, 0);

    // Periodic ack keeps the watchdog from firing.
    apply_reset();
    bus.ma_req = 4'b0001;
    wait_gnt();
    bus.ma_select = 4'b0001;
    err_seen = 0;
    for (int i = 0; i < 40; i++) begin
      bus.sl_ack = (i % 6 == 5);
      tick();
      if (bus.timeout_err) err_seen++;
    end
    chk("ack_no_timeout", err_seen, 0);
    clear_inputs();
    tick();

    // Isolation: masked master never wins; mask mid-tenure kills silently.
    apply_reset();
    bus.ma_mask = 4'b0010;
    bus.ma_req  = 4'b0011;
    wait_gnt();
    for (int t = 0; t < 4; t++) begin
      chk("iso_gnt", bus.gnt, 4'b0001);
      bus.ma_select = 4'b0001;
      tick();
      bus.ma_select = '0;
      tick();
    end
    bus.ma_select = 4'b0001;
    tick();
    tick();
    bus.ma_mask = 4'b0011;
    tick();
    chk("iso_kill_valid", bus.cur_valid, 0);
    chk("iso_kill_noerr", bus.timeout_err, 0);
    clear_inputs();
    tick();

    // Timeout set beats a same-cycle clear.
    apply_reset();
    bus.ma_req = 4'b1000;
    wait_gnt();
    bus.ma_select = 4'b1000;
    wait_abort();
    bus.status_clr = 4'b1000;
    tick();
    chk("set_over_clr", bus.timeout_status, 4'b1000);
    clear_inputs();
    tick();

    // Asynchronous reset mid-tenure.
    bus.ma_req = 4'b0100;
    wait_gnt();
    bus.ma_select = 4'b0100;
    tick();
    tick();
    chk("pre_rst_valid", bus.cur_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", bus.cur_valid, 0);
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bus.ma_req = 4'b1111;
    wait_gnt();
    chk("post_rst_gnt", bus.gnt, 4'b0001);

    // Randomized traffic against the model.
    apply_reset();
    rand_cycles(1500, 30, 5, 10);
    rand_cycles(1500, 2, 2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
